probador_sumador: RTL
=====================

PROBADOR_SUMADOR -- requirements
Module: probador_sumador

Interface
REQ-001 Parameter LATENCY, default 2, SHALL be the pipeline depth in cycles of the adder under test (legal range 1-8).
REQ-002 Parameter NUM_VECTORS, default 32, SHALL be the total vectors per run (legal range 4-255).
REQ-003 Parameter SEED, default 8'hA5, SHALL be the LFSR reload value and SHALL be non-zero.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  run request, sampled only in IDLE or DONE.
REQ-007 ready_in  input  1  downstream accepts the current vector.
REQ-008 checks_in  input  1  checker verdict, 1 = both adder models match.
REQ-009 dato_A  output  4  operand A to both adder models.
REQ-010 dato_B  output  4  operand B to both adder models.
REQ-011 valid_out  output  1  dato_A/dato_B hold a vector.
REQ-012 salida_esperada  output  5  expected sum dato_A+dato_B, delayed by LATENCY.
REQ-013 esperada_valid  output  1  salida_esperada is meaningful this cycle.
REQ-014 busy  output  1  run in progress.
REQ-015 done  output  1  run complete.
REQ-016 error_count  output  8  mismatches seen this run, saturating.

Function
REQ-017 The FSM SHALL have states IDLE, CORNER, RANDOM, DRAIN and DONE.
REQ-018 IDLE/DONE with start=1 SHALL go to CORNER next cycle, clear error_count, reload LFSR with SEED and clear vec_count and done.
REQ-019 start SHALL be ignored in CORNER, RANDOM and DRAIN.
REQ-020 A transfer SHALL occur on a cycle with valid_out=1 and ready_in=1; vec_count SHALL increment by 1 per transfer.
REQ-021 While valid_out=1 and ready_in=0, dato_A, dato_B and valid_out SHALL hold stable.
REQ-022 CORNER SHALL issue, in order, (A,B) = (0,0), (F,F), (F,1), (8,8), each held until transferred, then go to RANDOM.
REQ-023 In RANDOM, dato_A SHALL be lfsr[7:4] and dato_B SHALL be lfsr[3:0], using an 8-bit Fibonacci LFSR with taps 8,6,5,4 that advances only on a RANDOM transfer.
REQ-024 The transfer with vec_count = NUM_VECTORS-1 SHALL move to DRAIN and drop valid_out in the following cycle.
REQ-025 valid_out SHALL be 1 throughout CORNER and RANDOM and 0 in IDLE, DRAIN and DONE.
REQ-026 The expected pipeline SHALL shift every cycle regardless of ready_in, with data = 5-bit zero-extended A+B (carry in bit 4) and a valid bit = transfer.
REQ-027 For a transfer at cycle N, esperada_valid=1 and salida_esperada SHALL appear at cycle N+LATENCY.
REQ-028 DRAIN SHALL last exactly LATENCY cycles, then enter DONE with busy=0 and done=1.
REQ-029 done SHALL stay 1 until the next accepted start.
REQ-030 busy SHALL be 1 in CORNER, RANDOM and DRAIN.
REQ-031 On a cycle with esperada_valid=1 and checks_in=0, error_count SHALL increment.
REQ-032 error_count SHALL saturate at 255, and checks_in SHALL be ignored when esperada_valid=0.

Reset
REQ-033 While reset=1, regardless of clk: state=IDLE; lfsr=SEED; vec_count=0; all pipeline stages=0; dato_A, dato_B, valid_out, salida_esperada, esperada_valid, busy, done and error_count=0.
REQ-034 Reset asserted mid-run SHALL abort the run with no pending expected values emitted afterward.
REQ-035 The first start after reset deasserts SHALL begin a fresh run.

Verification
REQ-036 Defaults, ready_in=1, checks_in=1, start pulse -> cycles 1-4 show (0,0),(F,F),(F,1),(8,8); salida_esperada 00,1E,10,10 two cycles later; done after 32 transfers+2; error_count=0.
REQ-037 ready_in=0 for 3 cycles during (F,1) -> operands and valid_out frozen; vector and its expected value appear once, no LFSR advance.
REQ-038 checks_in=0 on 3 esperada_valid cycles and 2 invalid cycles -> error_count=3.
REQ-039 NUM_VECTORS=4, checks_in=0 forced for 300 runs of re-start -> error_count per run=4, saturation checked separately by holding checks_in=0 with NUM_VECTORS=255 -> 255, no wrap.
REQ-040 reset pulse during RANDOM -> all outputs 0 asynchronously, no esperada_valid afterward; next start repeats the identical vector sequence.
REQ-041 start asserted during RANDOM and DRAIN -> no effect; start in DONE -> new run, error_count cleared, same sequence as the first run.

Source files
------------

// File: rtl/probador_sumador.sv
// Stimulus generator for a pipelined 4-bit adder: four corner vectors, then LFSR vectors,
// with a LATENCY-deep expected-sum pipeline and a saturating mismatch counter.
module probador_sumador #(
    parameter int         LATENCY     = 2,
    parameter int         NUM_VECTORS = 32,
    parameter logic [7:0] SEED        = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       ready_in,
    input  logic       checks_in,
    output logic [3:0] dato_A,
    output logic [3:0] dato_B,
    output logic       valid_out,
    output logic [4:0] salida_esperada,
    output logic       esperada_valid,
    output logic       busy,
    output logic       done,
    output logic [7:0] error_count
);

    typedef enum logic [2:0] {S_IDLE, S_CORNER, S_RANDOM, S_DRAIN, S_DONE} state_t;

    localparam logic [7:0] LAST_VEC   = 8'(NUM_VECTORS - 1);
    localparam logic [2:0] DRAIN_LOAD = 3'(LATENCY - 1);

    state_t             state_q, state_d;
    logic [7:0]         lfsr_q, lfsr_d;
    logic [7:0]         vec_q, vec_d;
    logic [7:0]         err_q, err_d;
    logic [2:0]         drain_q, drain_d;
    logic [LATENCY-1:0] pv_q;
    logic [4:0]         pd_q [LATENCY];
    logic               xfer;
    logic               last_vec;
    logic [4:0]         sum;

    assign xfer            = valid_out & ready_in;
    assign last_vec        = (vec_q == LAST_VEC);
    assign sum             = {1'b0, dato_A} + {1'b0, dato_B};
    assign salida_esperada = pd_q[LATENCY-1];
    assign esperada_valid  = pv_q[LATENCY-1];
    assign error_count     = err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            lfsr_q  <= SEED;
            vec_q   <= '0;
            err_q   <= '0;
            drain_q <= '0;
            pv_q    <= '0;
            for (int i = 0; i < LATENCY; i++) pd_q[i] <= '0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            vec_q   <= vec_d;
            err_q   <= err_d;
            drain_q <= drain_d;
            // expected pipeline shifts every cycle, independent of back-pressure
            pv_q[0] <= xfer;
            pd_q[0] <= sum;
            for (int i = LATENCY - 1; i > 0; i--) begin
                pv_q[i] <= pv_q[i-1];
                pd_q[i] <= pd_q[i-1];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        vec_d   = vec_q;
        drain_d = drain_q;
        err_d   = err_q;
        if (esperada_valid && !checks_in && err_q != 8'hFF) err_d = err_q + 8'd1;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_CORNER;
                    lfsr_d  = SEED;
                    vec_d   = '0;
                    err_d   = '0;
                end
            end
            S_CORNER: begin
                if (xfer) begin
                    vec_d = vec_q + 8'd1;
                    if (last_vec) begin
                        state_d = S_DRAIN;
                        drain_d = DRAIN_LOAD;
                    end else if (vec_q == 8'd3) begin
                        state_d = S_RANDOM;
                    end
                end
            end
            S_RANDOM: begin
                if (xfer) begin
                    vec_d  = vec_q + 8'd1;
                    lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
                    if (last_vec) begin
                        state_d = S_DRAIN;
                        drain_d = DRAIN_LOAD;
                    end
                end
            end
            S_DRAIN: begin
                if (drain_q == 3'd0) state_d = S_DONE;
                else                 drain_d = drain_q - 3'd1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        dato_A    = '0;
        dato_B    = '0;
        valid_out = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state_q)
            S_CORNER: begin
                valid_out = 1'b1;
                busy      = 1'b1;
                case (vec_q[1:0])
                    2'd0:    begin dato_A = 4'h0; dato_B = 4'h0; end
                    2'd1:    begin dato_A = 4'hF; dato_B = 4'hF; end
                    2'd2:    begin dato_A = 4'hF; dato_B = 4'h1; end
                    default: begin dato_A = 4'h8; dato_B = 4'h8; end
                endcase
            end
            S_RANDOM: begin
                valid_out = 1'b1;
                busy      = 1'b1;
                dato_A    = lfsr_q[7:4];
                dato_B    = lfsr_q[3:0];
            end
            S_DRAIN: busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

endmodule
